multi_rate_counter: RTL and testbench



---
 rtl/multi_rate_counter.sv | 162 ++++++++++++++++
 tb/tb_multi_rate_counter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_rate_counter.sv
// multi_rate_counter: multi-channel pulse-rate counter.
// Each channel synchronises an asynchronous input, detects the selected edge
// type and counts edges over a common gate window. At the end of every window
// all channel counts are published together with a one-cycle strobe.
//
// Optional feature macro: RATE_CNT_GATE_PORT_EN
//   defined   -> GateCycles port sets the window length, resampled per window
//   undefined -> window length is the CLK_RATE parameter
//
// Output strobe semantics: RateValid is a one-cycle pulse with no back-pressure.
// Rate/Overflow change only on the clock edge that raises RateValid, and hold
// their values until the next publication.
module multi_rate_counter #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 32,
    parameter int CLK_RATE    = 50000000,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic                      Clk,
    input  logic                      nReset,
    input  logic                      Enable,
    input  logic [CHANNELS-1:0]       In,
`ifdef RATE_CNT_GATE_PORT_EN
    input  logic [31:0]               GateCycles,
`endif
    output logic [CHANNELS*WIDTH-1:0] Rate,
    output logic [CHANNELS-1:0]       Overflow,
    output logic                      RateValid
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [CHANNELS-1:0]       r_sync [SYNC_STAGES];
    logic [CHANNELS-1:0]       r_hist;
    logic [CHANNELS-1:0]       w_sync_out;
    logic [CHANNELS-1:0]       w_edge;
    logic [31:0]               r_gcnt;
    logic [31:0]               w_gl;
    logic                      w_terminal;
    logic [WIDTH-1:0]          r_cnt [CHANNELS];
    logic [CHANNELS-1:0]       r_sat;
    logic [CHANNELS*WIDTH-1:0] r_rate;
    logic [CHANNELS-1:0]       r_ovf;
    logic                      r_valid;

    // Synchroniser chain and history flop; free-running so Enable never fakes an edge.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_hist <= '0;
        end else begin
            r_sync[0] <= In;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_hist <= w_sync_out;
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Edge detection on (synchronised value, previous value).
    always_comb begin
        case (EDGE_MODE)
            1:       w_edge = ~w_sync_out & r_hist;
            2:       w_edge = w_sync_out ^ r_hist;
            default: w_edge = w_sync_out & ~r_hist;
        endcase
    end

`ifdef RATE_CNT_GATE_PORT_EN
    logic        r_run;
    logic [31:0] r_gl;
    logic [31:0] w_gate_in;

    // A zero-length request behaves as a one-cycle window.
    assign w_gate_in = (GateCycles == 32'd0) ? 32'd1 : GateCycles;
    // On the first enabled cycle the window length comes straight from the port.
    assign w_gl      = r_run ? r_gl : w_gate_in;

    // Window length register: loaded on the first enabled cycle and at each terminal cycle.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_run <= 1'b0;
            r_gl  <= 32'(CLK_RATE);
        end else begin
            r_run <= Enable;
            if (Enable && (!r_run || w_terminal)) begin
                r_gl <= w_gate_in;
            end
        end
    end
`else
    assign w_gl = 32'(CLK_RATE);
`endif

    assign w_terminal = Enable && (r_gcnt == (w_gl - 32'd1));

    // Gate counter: counts 0..Gl-1 while enabled, held at zero otherwise.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_gcnt <= '0;
        end else if (!Enable || w_terminal) begin
            r_gcnt <= '0;
        end else begin
            r_gcnt <= r_gcnt + 32'd1;
        end
    end

    // Per-channel saturating edge counters and sticky saturation flags.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int n = 0; n < CHANNELS; n++) begin
                r_cnt[n] <= '0;
            end
            r_sat <= '0;
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (!Enable || w_terminal) begin
                    r_cnt[n] <= '0;
                    r_sat[n] <= 1'b0;
                end else if (w_edge[n]) begin
                    if (r_cnt[n] == CNT_MAX) begin
                        r_sat[n] <= 1'b1;
                    end else begin
                        r_cnt[n] <= r_cnt[n] + WIDTH'(1);
                    end
                end
            end
        end
    end

    // Publication: terminal-cycle edges still belong to the ending window.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_rate  <= '0;
            r_ovf   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_terminal;
            if (w_terminal) begin
                for (int n = 0; n < CHANNELS; n++) begin
                    if (w_edge[n] && (r_cnt[n] == CNT_MAX)) begin
                        r_rate[n*WIDTH +: WIDTH] <= CNT_MAX;
                        r_ovf[n]                 <= 1'b1;
                    end else begin
                        r_rate[n*WIDTH +: WIDTH] <= r_cnt[n] + WIDTH'(w_edge[n]);
                        r_ovf[n]                 <= r_sat[n];
                    end
                end
            end
        end
    end

    assign Rate      = r_rate;
    assign Overflow  = r_ovf;
    assign RateValid = r_valid;

endmodule

// File: tb/tb_multi_rate_counter.sv
// Bench for multi_rate_counter: four instances (100-cycle rising, 600-cycle
// rising, 100-cycle both-edge, 1-cycle falling) share clock, reset, Enable and
// inputs. A behavioural model counts edges as plain integers per window and
// saturates only at publication; every cycle all outputs are compared to it.
module tb_multi_rate_counter;

    localparam int NI = 4;
    localparam int S  = 2;

    function automatic int gl_fix(input int i);
        case (i)
            1:       return 600;
            3:       return 1;
            default: return 100;
        endcase
    endfunction

    function automatic int mode_of(input int i);
        case (i)
            2:       return 2;
            3:       return 1;
            default: return 0;
        endcase
    endfunction

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  in_v;
    logic [31:0] gate_cycles;
    logic [15:0] rate_o [NI];
    logic [1:0]  ovf_o  [NI];
    logic        vld_o  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        multi_rate_counter #(
            .CHANNELS    (2),
            .WIDTH       (8),
            .CLK_RATE    (gl_fix(g)),
            .SYNC_STAGES (S),
            .EDGE_MODE   (mode_of(g))
        ) u_dut (
            .Clk        (clk),
            .nReset     (rst_n),
            .Enable     (en),
            .In         (in_v),
`ifdef RATE_CNT_GATE_PORT_EN
            .GateCycles (gate_cycles),
`endif
            .Rate       (rate_o[g]),
            .Overflow   (ovf_o[g]),
            .RateValid  (vld_o[g])
        );
    end

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard / model state
    int          n_assert = 0;
    int          n_fail   = 0;
    int          k_tick   = 0;
    int          stim     = 0;
    logic [1:0]  samp [$];
    int          m_cyc [NI];
    int          m_gl  [NI];
    int          m_tot [NI][2];
    logic        m_prev [NI];
    logic [15:0] e_rate [NI];
    logic [1:0]  e_ovf  [NI];
    logic        e_vld  [NI];
    logic [15:0] exp_q [$];

    function automatic int edge_of(input int mode, input logic o, input logic n);
        case (mode)
            1:       return (o && !n) ? 1 : 0;
            2:       return (o != n) ? 1 : 0;
            default: return (!o && n) ? 1 : 0;
        endcase
    endfunction

    function automatic int gate_len(input int i);
`ifdef RATE_CNT_GATE_PORT_EN
        return (gate_cycles == 32'd0) ? 1 : int'(gate_cycles);
`else
        return gl_fix(i);
`endif
    endfunction

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    task automatic model_reset();
        samp.delete();
        for (int j = 0; j <= S; j++) samp.push_back(2'b00);
        for (int i = 0; i < NI; i++) begin
            m_cyc[i]    = 0;
            m_gl[i]     = 1;
            m_tot[i][0] = 0;
            m_tot[i][1] = 0;
            m_prev[i]   = 1'b0;
            e_rate[i]   = '0;
            e_ovf[i]    = '0;
            e_vld[i]    = 1'b0;
        end
        exp_q.delete();
    endtask

    // The counting logic sees the input as sampled S and S+1 edges ago.
    task automatic model_step();
        logic [1:0] s_old;
        logic [1:0] s_new;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s_old = samp[0];
        s_new = samp[1];
        samp.push_back(in_v);
        samp.delete(0);
        for (int i = 0; i < NI; i++) begin
            if (!en) begin
                m_cyc[i]    = 0;
                m_tot[i][0] = 0;
                m_tot[i][1] = 0;
                e_vld[i]    = 1'b0;
                m_prev[i]   = 1'b0;
            end else begin
                if (!m_prev[i]) m_gl[i] = gate_len(i);
                m_prev[i] = 1'b1;
                for (int c = 0; c < 2; c++) begin
                    m_tot[i][c] += edge_of(mode_of(i), s_old[c], s_new[c]);
                end
                m_cyc[i]++;
                e_vld[i] = 1'b0;
                if (m_cyc[i] == m_gl[i]) begin
                    for (int c = 0; c < 2; c++) begin
                        e_rate[i][c*8 +: 8] = (m_tot[i][c] > 255) ? 8'd255 : 8'(m_tot[i][c]);
                        e_ovf[i][c]         = (m_tot[i][c] > 255);
                        m_tot[i][c]         = 0;
                    end
                    e_vld[i] = 1'b1;
                    m_cyc[i] = 0;
                    m_gl[i]  = gate_len(i);
                    if (i == 0) exp_q.push_back(e_rate[i]);
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk("rate", i, {16'h0, rate_o[i]}, {16'h0, e_rate[i]});
            chk("ovf", i, {30'h0, ovf_o[i]}, {30'h0, e_ovf[i]});
            chk("vld", i, {31'h0, vld_o[i]}, {31'h0, e_vld[i]});
        end
        if (vld_o[0]) begin
            if (exp_q.size() > 0) chk("pub", 0, {16'h0, rate_o[0]}, {16'h0, exp_q.pop_front()});
            else chk("pub_q_empty", 0, {31'h0, vld_o[0]}, 32'd0);
        end
    endtask

    task automatic drive_stim();
        case (stim)
            1: in_v = {1'b0, (k_tick % 10) < 5};
            2: in_v = {(k_tick % 2) == 1, (k_tick % 10) < 5};
            3: in_v = {(k_tick % 12) < 6, (k_tick % 10) < 5};
            4: begin
                in_v = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 149) == 0) en = ~en;
            end
            5: in_v = {1'b0, (k_tick % 20) < 10};
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        k_tick++;
        drive_stim();
    endtask

    task automatic wait_valid(input int i, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!vld_o[i] && n < budget);
        chk("vld_wait", i, {31'h0, vld_o[i]}, 32'd1);
    endtask

    int n;

    initial begin
        rst_n       = 1'b0;
        en          = 1'b0;
        in_v        = 2'b01;
        gate_cycles = 32'd100;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // Periodic ch0 input, first publication latency and counts.
        en   = 1'b1;
        stim = 1;
        wait_valid(0, 200, n);
        chk("first_latency", 0, n, 100);
        wait_valid(0, 200, n);
        chk("sq10_rate", 0, {24'h0, rate_o[0][7:0]}, 32'd10);
        chk("sq10_ch1", 0, {24'h0, rate_o[0][15:8]}, 32'd0);
        chk("sq10_ovf", 0, {30'h0, ovf_o[0]}, 32'd0);
        chk("both_rate", 2, {24'h0, rate_o[2][7:0]}, 32'd20);
        chk("gl1_vld", 3, {31'h0, vld_o[3]}, 32'd1);

`ifndef RATE_CNT_GATE_PORT_EN
        // Saturation on the 600-cycle instance, then recovery.
        stim = 2;
        repeat (2) wait_valid(1, 700, n);
        chk("sat_rate", 1, {24'h0, rate_o[1][15:8]}, 32'd255);
        chk("sat_ovf", 1, {31'h0, ovf_o[1][1]}, 32'd1);
        stim = 3;
        repeat (3) wait_valid(1, 700, n);
        chk("unsat_rate", 1, {24'h0, rate_o[1][15:8]}, 32'd50);
        chk("unsat_ovf", 1, {31'h0, ovf_o[1][1]}, 32'd0);
        chk("unsat_ch0", 1, {24'h0, rate_o[1][7:0]}, 32'd60);
`endif

        // Enable dropped mid-window.
        stim = 1;
        wait_valid(0, 200, n);
        repeat (50) tick();
        en = 1'b0;
        repeat (30) begin
            tick();
            chk("idle_vld", 0, {31'h0, vld_o[0]}, 32'd0);
        end
        en = 1'b1;
        wait_valid(0, 200, n);
        chk("reenable_latency", 0, n, 100);

        // Edge counted on the terminal cycle belongs to the ending window.
        stim = 0;
        in_v = 2'b00;
        wait_valid(0, 200, n);
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (k == 100) begin
                chk("term_rate", 0, {24'h0, rate_o[0][7:0]}, 32'd5);
                chk("term_vld", 0, {31'h0, vld_o[0]}, 32'd1);
            end
            if (k == 200) begin
                chk("after_term_rate", 0, {24'h0, rate_o[0][7:0]}, 32'd0);
                chk("after_term_vld", 0, {31'h0, vld_o[0]}, 32'd1);
            end
            in_v[0] = ((k >= 10 && k < 15) || (k >= 30 && k < 35) || (k >= 50 && k < 55) ||
                       (k >= 70 && k < 75) || (k >= 97 && k < 103));
        end

        // Both-edge square wave, then asynchronous reset mid-window.
        stim = 5;
        repeat (3) wait_valid(2, 200, n);
        chk("sq20_both", 2, {24'h0, rate_o[2][7:0]}, 32'd10);
        chk("sq20_rise", 0, {24'h0, rate_o[0][7:0]}, 32'd5);
        repeat (40) tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < NI; i++) begin
            chk("rst_rate", i, {16'h0, rate_o[i]}, 32'd0);
            chk("rst_ovf", i, {30'h0, ovf_o[i]}, 32'd0);
            chk("rst_vld", i, {31'h0, vld_o[i]}, 32'd0);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        wait_valid(0, 200, n);
        chk("post_rst_latency", 0, n, 100);

        // Random inputs and random Enable toggling against the model.
        stim = 4;
        repeat (2000) tick();
        en   = 1'b1;
        stim = 1;
        repeat (5) tick();

`ifdef RATE_CNT_GATE_PORT_EN
        // Runtime window length.
        gate_cycles = 32'd20;
        wait_valid(0, 200, n);
        wait_valid(0, 100, n);
        chk("gate20", 0, n, 20);
        repeat (5) tick();
        gate_cycles = 32'd40;
        wait_valid(0, 100, n);
        chk("gate20_tail", 0, n, 15);
        wait_valid(0, 100, n);
        chk("gate40", 0, n, 40);
        gate_cycles = 32'd0;
        wait_valid(0, 100, n);
        repeat (5) begin
            tick();
            chk("gate0_vld", 0, {31'h0, vld_o[0]}, 32'd1);
        end
`endif

        chk("pub_q_drained", 0, exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
